// File: rtl/delta_cep_window_calc_pkg.sv
// Purpose : shared constants, FSM encoding and ring-slot helper for the MFCC delta stage.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package mfcc_delta_pkg;

    // Default coefficient width and frame length of the cepstrum stream.
    localparam int CEP_DATA_WIDTH = 16;
    localparam int NUM_CEP        = 13;

    // Number of frames held in the ring: t-2, t-1, t, t+1, t+2.
    localparam int DELTA_WIN      = 5;

    localparam logic [2:0] LAST_SLOT = 3'(DELTA_WIN - 1);
    localparam logic [2:0] WIN_FULL  = 3'(DELTA_WIN);

    typedef enum logic {
        FILL    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    // (slot - off) mod DELTA_WIN, for slot in 0..4 and off in 0..5.
    function automatic logic [2:0] slot_sub(input logic [2:0] slot, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, slot} + 4'd5 - {1'b0, off};
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[2:0];
    endfunction

    // (slot + 1) mod DELTA_WIN.
    function automatic logic [2:0] slot_inc(input logic [2:0] slot);
        return (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
    endfunction

endpackage

// File: rtl/delta_coef_index_cnt.sv
// Purpose : modulo (limit+1) coefficient index counter with synchronous clear.
// Latency : out_o updates on the edge after en_i; over_o is combinational (out_o == limit_i).
// Backpressure : none; counts only when en_i is high.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        synchronous return to 0 (wins over en_i)
//   en_i         advance by one this edge, wrapping to 0 after limit_i
//   limit_i      last index value
//   out_o        current index
//   over_o       current index is the last one; an enabled edge wraps
module delta_coef_index_cnt #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] out_o,
    output logic             over_o
);
    import mfcc_delta_pkg::*;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign over_o = (cnt_q == limit_i);
    assign out_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = over_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/delta_cep_window_calc.sv
// Purpose : 5-frame ring window over the cepstrum stream; emits unnormalised deltas of the centre frame.
// Latency : first delta 1 cycle after the frame-completing transfer, then one coefficient per cycle.
// Backpressure : cep_in_ready low for NUM_CEP cycles while a delta frame is produced; delta output has none.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush of window state and any delta frame in progress
//   cep_in_valid/_data/_ready   coefficient input handshake, index implied by arrival order
//   delta_valid       delta_data/delta_idx valid this cycle
//   delta_data        d[k] = (c[t+1]-c[t-1]) + 2*(c[t+2]-c[t-2]), signed, not divided by 10
//   delta_idx         coefficient index k
//   delta_frame_end   marks k = NUM_CEP-1
module delta_cep_window_calc #(
    parameter int DATA_WIDTH = mfcc_delta_pkg::CEP_DATA_WIDTH,
    parameter int NUM_CEP    = mfcc_delta_pkg::NUM_CEP,
    parameter int IDX_WIDTH  = 7,
    parameter int OUT_WIDTH  = DATA_WIDTH + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  cep_in_valid,
    input  logic [DATA_WIDTH-1:0] cep_in_data,
    output logic                  cep_in_ready,
    output logic                  delta_valid,
    output logic [OUT_WIDTH-1:0]  delta_data,
    output logic [IDX_WIDTH-1:0]  delta_idx,
    output logic                  delta_frame_end
);
    import mfcc_delta_pkg::*;

    // Address width of the coefficient dimension of the window array.
    localparam int AW = (NUM_CEP > 1) ? $clog2(NUM_CEP) : 1;
    localparam logic [IDX_WIDTH-1:0] IDX_LIMIT = IDX_WIDTH'(NUM_CEP - 1);

    state_t                 state_q, state_d;
    logic [2:0]             wr_slot_q, wr_slot_d;
    logic [2:0]             frames_filled_q, frames_filled_d;
    logic [2:0]             frames_inc;

    logic                   delta_valid_q, delta_valid_d;
    logic [OUT_WIDTH-1:0]   delta_data_q, delta_data_d;
    logic [IDX_WIDTH-1:0]   delta_idx_q, delta_idx_d;
    logic                   delta_frame_end_q, delta_frame_end_d;

    logic [IDX_WIDTH-1:0]   wr_idx;
    logic                   wr_over;
    logic [IDX_WIDTH-1:0]   rd_idx;
    logic                   rd_over;

    logic                   xfer;
    logic                   frame_done;
    logic                   compute_en;

    // Window storage: four simultaneous reads per cycle, so kept in flops.
    // Not reset; frames_filled guarantees stale contents are never used.
    logic signed [DATA_WIDTH-1:0] window_q [DELTA_WIN][NUM_CEP];

    logic [2:0]             slot_p2, slot_p1, slot_m1, slot_m2;
    logic [AW-1:0]          wr_a, rd_a;
    logic signed [DATA_WIDTH-1:0] win_p2, win_p1, win_m1, win_m2;
    logic signed [OUT_WIDTH-1:0]  ext_p2, ext_p1, ext_m1, ext_m2;
    logic signed [OUT_WIDTH-1:0]  delta_calc;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign cep_in_ready = (state_q == FILL);
    // clear wins over a simultaneous transfer: nothing is written that edge.
    assign xfer         = cep_in_valid & cep_in_ready & ~clear;
    assign frame_done   = xfer & wr_over;
    assign compute_en   = (state_q == COMPUTE) & ~clear;

    // ------------------------------------------------------------------
    // Index counters
    // ------------------------------------------------------------------
    delta_coef_index_cnt #(
        .WIDTH   (IDX_WIDTH)
    ) u_wr_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear),
        .en_i    (xfer),
        .limit_i (IDX_LIMIT),
        .out_o   (wr_idx),
        .over_o  (wr_over)
    );

    // The read counter wraps to 0 on the last COMPUTE edge, so it is
    // already at 0 when the next delta frame starts.
    delta_coef_index_cnt #(
        .WIDTH   (IDX_WIDTH)
    ) u_rd_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear),
        .en_i    (compute_en),
        .limit_i (IDX_LIMIT),
        .out_o   (rd_idx),
        .over_o  (rd_over)
    );

    assign wr_a = wr_idx[AW-1:0];
    assign rd_a = rd_idx[AW-1:0];

    // ------------------------------------------------------------------
    // Window write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (xfer) begin
            window_q[wr_slot_q][wr_a] <= cep_in_data;
        end
    end

    // ------------------------------------------------------------------
    // Delta datapath
    // ------------------------------------------------------------------
    // In COMPUTE wr_slot_q already points past the newest frame n, so
    // t+2 = wr_slot-1, t+1 = wr_slot-2, t-1 = wr_slot-4, t-2 = wr_slot-5 = wr_slot.
    assign slot_p2 = slot_sub(wr_slot_q, 3'd1);
    assign slot_p1 = slot_sub(wr_slot_q, 3'd2);
    assign slot_m1 = slot_sub(wr_slot_q, 3'd4);
    assign slot_m2 = slot_sub(wr_slot_q, 3'd5);

    assign win_p2 = window_q[slot_p2][rd_a];
    assign win_p1 = window_q[slot_p1][rd_a];
    assign win_m1 = window_q[slot_m1][rd_a];
    assign win_m2 = window_q[slot_m2][rd_a];

    // Sign-extend first; the full-range result (3 * 65535 for 16-bit data)
    // fits exactly in DATA_WIDTH+3 bits, so no saturation is needed.
    assign ext_p2 = OUT_WIDTH'(win_p2);
    assign ext_p1 = OUT_WIDTH'(win_p1);
    assign ext_m1 = OUT_WIDTH'(win_m1);
    assign ext_m2 = OUT_WIDTH'(win_m2);

    assign delta_calc = (ext_p1 - ext_m1) + ((ext_p2 - ext_m2) <<< 1);

    // ------------------------------------------------------------------
    // FSM next state and registered outputs
    // ------------------------------------------------------------------
    assign frames_inc = (frames_filled_q == WIN_FULL) ? WIN_FULL : frames_filled_q + 3'd1;

    always_comb begin
        state_d           = state_q;
        wr_slot_d         = wr_slot_q;
        frames_filled_d   = frames_filled_q;
        delta_valid_d     = 1'b0;
        delta_data_d      = delta_data_q;
        delta_idx_d       = delta_idx_q;
        delta_frame_end_d = 1'b0;

        if (clear) begin
            // Truncates any delta frame in progress without a frame_end.
            state_d         = FILL;
            wr_slot_d       = 3'd0;
            frames_filled_d = 3'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (frame_done) begin
                        wr_slot_d       = slot_inc(wr_slot_q);
                        frames_filled_d = frames_inc;
                        if (frames_inc == WIN_FULL) begin
                            state_d = COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    delta_valid_d     = 1'b1;
                    delta_idx_d       = rd_idx;
                    delta_data_d      = delta_calc;
                    delta_frame_end_d = rd_over;
                    if (rd_over) begin
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= FILL;
            wr_slot_q         <= 3'd0;
            frames_filled_q   <= 3'd0;
            delta_valid_q     <= 1'b0;
            delta_data_q      <= '0;
            delta_idx_q       <= '0;
            delta_frame_end_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            wr_slot_q         <= wr_slot_d;
            frames_filled_q   <= frames_filled_d;
            delta_valid_q     <= delta_valid_d;
            delta_data_q      <= delta_data_d;
            delta_idx_q       <= delta_idx_d;
            delta_frame_end_q <= delta_frame_end_d;
        end
    end

    assign delta_valid     = delta_valid_q;
    assign delta_data      = delta_data_q;
    assign delta_idx       = delta_idx_q;
    assign delta_frame_end = delta_frame_end_q;

endmodule

// File: tb/tb_delta_cep_window_calc.sv
module tb_delta_cep_window_calc;
    localparam int NC = 13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        cep_in_valid;
    logic [15:0] cep_in_data;
    logic        cep_in_ready;
    logic        delta_valid;
    logic [18:0] delta_data;
    logic [6:0]  delta_idx;
    logic        delta_frame_end;

    always #5 clk = ~clk;

    delta_cep_window_calc #(
        .DATA_WIDTH (16),
        .NUM_CEP    (NC),
        .IDX_WIDTH  (7),
        .OUT_WIDTH  (19)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .cep_in_valid    (cep_in_valid),
        .cep_in_data     (cep_in_data),
        .cep_in_ready    (cep_in_ready),
        .delta_valid     (delta_valid),
        .delta_data      (delta_data),
        .delta_idx       (delta_idx),
        .delta_frame_end (delta_frame_end)
    );

    typedef struct {
        int data;
        int idx;
        int fe;
    } out_t;

    // One table row: five frames c[f][k] = v[f] + kslope*k, f=0 oldest, and the expected d.
    typedef struct {
        int v0, v1, v2, v3, v4;
        int kslope;
        int exp;
    } vec_t;

    out_t out_q[$];
    int   ready_runs[$];
    int   low_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    int   ob;

    // Monitor: record every delta beat and the length of every ready-low stretch.
    always @(negedge clk) begin
        out_t e;
        if (delta_valid) begin
            e.data = int'($signed(delta_data));
            e.idx  = int'(delta_idx);
            e.fe   = int'(delta_frame_end);
            out_q.push_back(e);
        end
        if (!cep_in_ready) begin
            low_cnt = low_cnt + 1;
        end else if (low_cnt > 0) begin
            ready_runs.push_back(low_cnt);
            low_cnt = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int v);
        int g;
        bit ok;
        g = 0;
        cep_in_data  = 16'(v);
        cep_in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = cep_in_ready;
            @(posedge clk);
            #1;
            g = g + 1;
        end while (!ok && g < 200);
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic feed_frame(input int base, input int ks);
        for (int k = 0; k < NC; k++) push(base + ks * k);
    endtask

    task automatic idle();
        cep_in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        cycles(1);
        ob = out_q.size();
    endtask

    // Wait (bounded) for n beats since ob, then confirm no extra beats follow.
    task automatic wait_out(input string nm, input int n);
        int g;
        g = 0;
        while (out_q.size() - ob < n && g < 300) begin
            cycles(1);
            g = g + 1;
        end
        cycles(3);
        chk({nm, "_beats"}, out_q.size() - ob, n);
    endtask

    task automatic check_frame(input string nm, input int start, input int exp);
        out_t e;
        for (int k = 0; k < NC; k++) begin
            if (ob + start + k < out_q.size()) begin
                e = out_q[ob + start + k];
            end else begin
                e.data = -999999;
                e.idx  = -1;
                e.fe   = -1;
            end
            chk({nm, "_data"}, e.data, exp);
            chk({nm, "_idx"}, e.idx, k);
            chk({nm, "_fe"}, e.fe, (k == NC - 1) ? 1 : 0);
        end
    endtask

    task automatic wait_idx(input int k);
        int g;
        g = 0;
        while (!(delta_valid && int'(delta_idx) == k) && g < 300) begin
            cycles(1);
            g = g + 1;
        end
        chk("wait_idx_seen", int'(delta_valid && int'(delta_idx) == k), 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ready"}, int'(cep_in_ready), 1);
        chk({nm, "_valid"}, int'(delta_valid), 0);
        chk({nm, "_data"}, int'(delta_data), 0);
        chk({nm, "_idx"}, int'(delta_idx), 0);
        chk({nm, "_fe"}, int'(delta_frame_end), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int fe_cnt;
        int rr0;

        vecs[0] = '{v0: 0,      v1: 10,     v2: 20, v3: 30,     v4: 40,     kslope: 1, exp: 100};
        vecs[1] = '{v0: 0,      v1: -10,    v2: -20, v3: -30,   v4: -40,    kslope: 1, exp: -100};
        vecs[2] = '{v0: -32768, v1: -32768, v2: 0,  v3: 32767,  v4: 32767,  kslope: 0, exp: 196605};
        vecs[3] = '{v0: 32767,  v1: 32767,  v2: 0,  v3: -32768, v4: -32768, kslope: 0, exp: -196605};
        vecs[4] = '{v0: 5,      v1: -3,     v2: 999, v3: 8,     v4: 1,      kslope: 3, exp: 3};
        vecs[5] = '{v0: 1,      v1: 2,      v2: 100, v3: 5,     v4: 7,      kslope: 2, exp: 15};

        rst_n        = 1'b0;
        clear        = 1'b0;
        cep_in_valid = 1'b0;
        cep_in_data  = 16'd0;
        ob           = 0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(2);

        // Table-driven windows: nothing before the fifth frame, then 13 beats of d.
        for (int i = 0; i < 6; i++) begin
            do_clear();
            feed_frame(vecs[i].v0, vecs[i].kslope);
            feed_frame(vecs[i].v1, vecs[i].kslope);
            feed_frame(vecs[i].v2, vecs[i].kslope);
            feed_frame(vecs[i].v3, vecs[i].kslope);
            idle();
            cycles(3);
            chk($sformatf("vec%0d_no_early", i), out_q.size() - ob, 0);
            feed_frame(vecs[i].v4, vecs[i].kslope);
            idle();
            wait_out($sformatf("vec%0d", i), NC);
            check_frame($sformatf("vec%0d", i), 0, vecs[i].exp);
        end

        // Ramp continued by a sixth frame: the window slides and yields a second frame of 100.
        do_clear();
        for (int f = 0; f < 6; f++) feed_frame(10 * f, 1);
        idle();
        wait_out("ramp6", 2 * NC);
        check_frame("ramp6_f0", 0, 100);
        check_frame("ramp6_f1", NC, 100);

        // Valid held high across 8 frames, c = 3f^2 + 7k -> d = 60*t for centre t = 2..5.
        do_clear();
        rr0 = ready_runs.size();
        for (int f = 0; f < 8; f++) feed_frame(3 * f * f, 7);
        idle();
        wait_out("stream", 4 * NC);
        check_frame("stream_t2", 0, 120);
        check_frame("stream_t3", NC, 180);
        check_frame("stream_t4", 2 * NC, 240);
        check_frame("stream_t5", 3 * NC, 300);
        chk("stream_ready_runs", ready_runs.size() - rr0, 4);
        for (int r = rr0; r < ready_runs.size(); r++) chk("stream_ready_low_len", ready_runs[r], NC);

        // clear while rd_idx = 6: beats 0..5 only, no frame_end, then a full refill is required.
        do_clear();
        for (int f = 0; f < 5; f++) feed_frame(10 * f, 1);
        idle();
        wait_idx(5);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("clear_valid_drop", int'(delta_valid), 0);
        chk("clear_ready", int'(cep_in_ready), 1);
        cycles(3);
        chk("clear_beats", out_q.size() - ob, 6);
        fe_cnt = 0;
        for (int j = ob; j < out_q.size(); j++) fe_cnt = fe_cnt + out_q[j].fe;
        chk("clear_no_fe", fe_cnt, 0);
        ob = out_q.size();
        feed_frame(vecs[5].v0, vecs[5].kslope);
        feed_frame(vecs[5].v1, vecs[5].kslope);
        feed_frame(vecs[5].v2, vecs[5].kslope);
        feed_frame(vecs[5].v3, vecs[5].kslope);
        idle();
        cycles(3);
        chk("clear_refill_no_early", out_q.size() - ob, 0);
        feed_frame(vecs[5].v4, vecs[5].kslope);
        idle();
        wait_out("clear_refill", NC);
        check_frame("clear_refill", 0, vecs[5].exp);

        // Asynchronous reset mid-COMPUTE, checked between clock edges, then refill from empty.
        ob = out_q.size();
        for (int f = 0; f < 5; f++) feed_frame(10 * f, 1);
        idle();
        wait_idx(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(2);
        ob = out_q.size();
        feed_frame(vecs[4].v0, vecs[4].kslope);
        feed_frame(vecs[4].v1, vecs[4].kslope);
        feed_frame(vecs[4].v2, vecs[4].kslope);
        feed_frame(vecs[4].v3, vecs[4].kslope);
        idle();
        cycles(3);
        chk("rst_refill_no_early", out_q.size() - ob, 0);
        feed_frame(vecs[4].v4, vecs[4].kslope);
        idle();
        wait_out("rst_refill", NC);
        check_frame("rst_refill", 0, vecs[4].exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
